// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word reads to a fixed-latency memory and
// delivers fetched instructions to decode through an output register plus a 1-entry skid.
module fetch_ctrl #(
  parameter int          NUM_INSTR = 5,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  input  logic              id_ready,
  output logic              halted
);

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;
  localparam logic [31:0] NUM_LIMIT = 32'(NUM_INSTR);

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        live_q;
  logic        inflight_q, inflight_d;
  logic [31:0] inflightPc_q, inflightPc_d;
  logic        outValid_q, outValid_d;
  logic [31:0] outPc_q, outPc_d;
  logic [31:0] outInstr_q, outInstr_d;
  logic        skidValid_q, skidValid_d;
  logic [31:0] skidPc_q, skidPc_d;
  logic [31:0] skidInstr_q, skidInstr_d;

  logic        inRange;
  logic        consume;
  logic        issue;
  logic        outFree;
  logic [31:0] redirectTarget;

  assign inRange        = ({2'b00, pc_q[31:2]} < NUM_LIMIT);
  assign consume        = outValid_q & id_ready;
  assign outFree        = ~outValid_q | consume;
  assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;

  // live_q holds off the first request until reset has been sampled high once.
  assign issue = reset & live_q & (state_q == RUN) & inRange & ~skidValid_q
               & ~(inflight_q & outValid_q & ~id_ready) & ~redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign if_valid  = outValid_q;
  assign if_pc     = outPc_q;
  assign if_instr  = outValid_q ? outInstr_q : 32'h0;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    outValid_d   = outValid_q;
    outPc_d      = outPc_q;
    outInstr_d   = outInstr_q;
    skidValid_d  = skidValid_q;
    skidPc_d     = skidPc_q;
    skidInstr_d  = skidInstr_q;

    if (issue) begin
      pc_d         = pc_q + 32'd4;
      inflight_d   = 1'b1;
      inflightPc_d = pc_q;
    end

    // The skid entry is always older than any returning data, so it refills first.
    if (outFree) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outPc_d     = skidPc_q;
        outInstr_d  = skidInstr_q;
        skidValid_d = 1'b0;
      end else if (inflight_q) begin
        outValid_d = 1'b1;
        outPc_d    = inflightPc_q;
        outInstr_d = imem_rdata;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skidValid_d = 1'b1;
      skidPc_d    = inflightPc_q;
      skidInstr_d = imem_rdata;
    end

    if (state_q == RUN && !inRange && !inflight_q && !skidValid_q && outFree) begin
      state_d = HALT;
    end

    if (redirect_valid) begin
      pc_d        = redirectTarget;
      state_d     = RUN;
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
      inflight_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      live_q       <= 1'b0;
      inflight_q   <= 1'b0;
      inflightPc_q <= 32'h0;
      outValid_q   <= 1'b0;
      outPc_q      <= 32'h0;
      outInstr_q   <= 32'h0;
      skidValid_q  <= 1'b0;
      skidPc_q     <= 32'h0;
      skidInstr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      live_q       <= 1'b1;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      outValid_q   <= outValid_d;
      outPc_q      <= outPc_d;
      outInstr_q   <= outInstr_d;
      skidValid_q  <= skidValid_d;
      skidPc_q     <= skidPc_d;
      skidInstr_q  <= skidInstr_d;
    end
  end

endmodule
